a2d_arbiter: RTL and testbench
==============================

// Module: a2d_arbiter
// PURPOSE
// - Shares the single A2D converter interface between two requesters: port 0 = motion controller (IR sensor reads),
//   port 1 = auxiliary monitor (battery and other housekeeping channels).
// - Sits between the requesters and the A2D interface. Queues one request per port and grants round-robin.
// - Launches one conversion at a time, routes the result back to the owner, and times out a hung converter.
// PARAMETERS
// - TIMEOUT_CYC  1023  cycles spent in CONVERT without a2d_cnv_cmplt before an abort
// - TMR_W        10    width of the timeout counter; must satisfy 2**TMR_W > TIMEOUT_CYC
// PORTS
// - clk           in   1   system clock
// - rst_n         in   1   asynchronous, active-low reset
// - strt_cnv0/1   in   1   one-cycle conversion request from port 0/1
// - chnnl0/1      in   3   channel for that request; sampled only when strt_cnvN=1
// - cnv_cmplt0/1  out  1   one-cycle completion pulse to port 0/1
// - res           out  12  result bus; valid while either cnv_cmplt pulse is high
// - busy0/1       out  1   port N has a request pending or in flight
// - a2d_strt_cnv  out  1   one-cycle start pulse to the A2D interface
// - a2d_chnnl     out  3   channel sent to the A2D; held stable from launch until completion or abort
// - a2d_cnv_cmplt in   1   conversion-done pulse from the A2D
// - a2d_res       in   12  A2D result; valid together with a2d_cnv_cmplt
// - a2d_err       out  1   sticky timeout flag; cleared only by reset
// BEHAVIOUR
// - Reset values: every output is 0. State=IDLE, pend0/1=0, last_gnt=1 (so port 0 wins the first tie), timer=0.
// - Request capture:
//   - strt_cnvN=1 while pendN=0 and port N is not in flight: set pendN and latch chnnlN, visible next cycle.
//   - strt_cnvN while busyN=1: ignored; the earlier channel is kept.
// - FSM states: IDLE, LAUNCH, CONVERT, DONE.
//   - IDLE: if any pend, grant round-robin. With both pending, grant the port != last_gnt. With one pending, grant it.
//     On a grant: register gnt, load a2d_chnnl from the latched channel, clear timer, go to LAUNCH.
//   - LAUNCH: a2d_strt_cnv=1 for exactly this cycle; go to CONVERT.
//   - CONVERT:
//     - a2d_cnv_cmplt=1: register res<=a2d_res, go to DONE.
//     - timer==TIMEOUT_CYC-1 with no completion: res<=12'h000, a2d_err<=1, go to DONE.
//     - Otherwise timer increments.
//   - DONE: cnv_cmplt[gnt]=1 for one cycle; clear pend[gnt]; last_gnt<=gnt; go to IDLE.
// - Uncontended latency:
//   - strt_cnvN in cycle t: pend at t+1, a2d_strt_cnv at t+2, cnv_cmplt at cycle (a2d_cnv_cmplt cycle + 2).
//   - Back-to-back grants are separated by 1 IDLE cycle.
// - a2d_cnv_cmplt outside CONVERT: ignored, with no effect on any state.
// - A new strt_cnv from the other port during any state is captured normally and does not disturb the active one.
// - Only one of cnv_cmplt0/1 is ever high in a cycle. res holds its value between completions.
// - busyN = pendN OR (gnt==N AND state!=IDLE).
// - A reset mid-conversion drops all pending and in-flight work: no completion pulse, a2d_err cleared.
// STRUCTURE
// - Package a2d_arb_pkg:
//   - arb_state_t enum {IDLE, LAUNCH, CONVERT, DONE}.
//   - A2D channel constants: CH_IN_L=0, CH_IN_R=1, CH_MID_L=2, CH_OUT_R=3, CH_MID_R=4, CH_OUT_L=7, CH_BATT=5.
// - One sub-module, a2d_rr_pick: combinational 2-way round-robin pick (pend[1:0], last_gnt -> gnt_vld, gnt).
// - FSM, request latches, timeout counter and result register live in the top level.
// TESTING
// - Single req: strt_cnv0 with chnnl0=3'b100, A2D model answers 12'h5A5 after 40 cycles.
//   -> a2d_chnnl=3'b100, a2d_strt_cnv at t+2, cnv_cmplt0 pulse with res=12'h5A5, busy0 low after it.
// - Simultaneous req: strt_cnv0 and strt_cnv1 in the same cycle, both from reset.
//   -> port 0 served first, then port 1; exactly two a2d_strt_cnv pulses; channels match.
// - Fairness: both ports re-request immediately after every completion, for 6 conversions.
//   -> grants alternate 0,1,0,1,0,1.
// - Duplicate req: strt_cnv0 chnnl0=1, then strt_cnv0 chnnl0=7 while busy0.
//   -> one conversion on channel 1 only, one cnv_cmplt0.
// - Timeout: A2D model never completes.
//   -> after TIMEOUT_CYC cycles: cnv_cmplt pulse with res=0, a2d_err=1 and sticky; next request still serviced.
// - Reset mid-CONVERT: assert rst_n=0 for 2 cycles.
//   -> all outputs 0, no cnv_cmplt; a late a2d_cnv_cmplt arriving in IDLE is ignored.

Source files
------------

// File: rtl/a2d_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// a2d_arb_pkg
// Shared types and constants for the A2D arbiter slice.
//   arb_state_t : arbiter FSM state encoding
//   CH_*        : A2D channel numbers used by the motion controller and the
//                 auxiliary monitor
//   CH_W/RES_W  : channel and result widths of the A2D interface
// ---------------------------------------------------------------------------
package a2d_arb_pkg;

    localparam int CH_W  = 3;
    localparam int RES_W = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    // IR sensor channels (port 0) and housekeeping channels (port 1)
    localparam logic [CH_W-1:0] CH_IN_L  = 3'd0;
    localparam logic [CH_W-1:0] CH_IN_R  = 3'd1;
    localparam logic [CH_W-1:0] CH_MID_L = 3'd2;
    localparam logic [CH_W-1:0] CH_OUT_R = 3'd3;
    localparam logic [CH_W-1:0] CH_MID_R = 3'd4;
    localparam logic [CH_W-1:0] CH_BATT  = 3'd5;
    localparam logic [CH_W-1:0] CH_OUT_L = 3'd7;

    // The port that must win a tie against the given last grantee
    function automatic logic rr_other(input logic last_gnt);
        return ~last_gnt;
    endfunction

endpackage

// File: rtl/a2d_arbiter_if.sv
// ---------------------------------------------------------------------------
// a2d_arbiter_if
// Bus between the arbiter and the single A2D converter interface.
//   a2d_strt_cnv  : one-cycle start pulse          (arbiter -> converter)
//   a2d_chnnl     : channel to convert             (arbiter -> converter)
//   a2d_cnv_cmplt : one-cycle conversion-done pulse (converter -> arbiter)
//   a2d_res       : result, valid with a2d_cnv_cmplt (converter -> arbiter)
// Modports: master = arbiter side, slave = converter side.
// ---------------------------------------------------------------------------
interface a2d_arbiter_if;
    import a2d_arb_pkg::*;

    logic              a2d_strt_cnv;
    logic [CH_W-1:0]   a2d_chnnl;
    logic              a2d_cnv_cmplt;
    logic [RES_W-1:0]  a2d_res;

    modport master (
        output a2d_strt_cnv,
        output a2d_chnnl,
        input  a2d_cnv_cmplt,
        input  a2d_res
    );

    modport slave (
        input  a2d_strt_cnv,
        input  a2d_chnnl,
        output a2d_cnv_cmplt,
        output a2d_res
    );

endinterface

// File: rtl/a2d_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// a2d_rr_pick
// Combinational two-way round-robin pick.
//   pend_i[1:0] : pending request per port
//   last_gnt_i  : port granted most recently
//   gnt_vld_o   : at least one port is pending
//   gnt_o       : chosen port (meaningful only when gnt_vld_o=1)
// With both ports pending the port that was not granted last wins; with a
// single port pending that port wins regardless of history.
// ---------------------------------------------------------------------------
module a2d_rr_pick
    import a2d_arb_pkg::*;
(
    input  logic [1:0] pend_i,
    input  logic       last_gnt_i,
    output logic       gnt_vld_o,
    output logic       gnt_o
);

    always_comb begin
        gnt_vld_o = |pend_i;
        gnt_o     = 1'b0;
        case (pend_i)
            2'b01:   gnt_o = 1'b0;
            2'b10:   gnt_o = 1'b1;
            2'b11:   gnt_o = rr_other(last_gnt_i);
            default: gnt_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/a2d_arbiter.sv
// ---------------------------------------------------------------------------
// a2d_arbiter
// Shares one A2D converter between port 0 (motion controller, IR sensors)
// and port 1 (auxiliary monitor, battery/housekeeping). Each port may queue
// one request; requests are granted round-robin, one conversion runs at a
// time, the result is routed back to the owner, and a converter that never
// answers is aborted after TIMEOUT_CYC cycles in CONVERT.
//
// Parameters
//   TIMEOUT_CYC : CONVERT cycles without a2d_cnv_cmplt before abort
//   TMR_W       : timeout counter width, 2**TMR_W must exceed TIMEOUT_CYC
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   strt_cnv0/1, chnnl0/1  : one-cycle request and its channel per port
//   cnv_cmplt0/1           : one-cycle completion pulse per port
//   res                    : result, valid while a cnv_cmplt pulse is high,
//                            held between completions
//   busy0/1                : request pending or in flight for that port
//   a2d_err                : sticky timeout flag, cleared only by reset
//   a2d                    : converter bus (master side)
// ---------------------------------------------------------------------------
module a2d_arbiter
    import a2d_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1023,
    parameter int TMR_W       = 10
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              strt_cnv0,
    input  logic [CH_W-1:0]   chnnl0,
    input  logic              strt_cnv1,
    input  logic [CH_W-1:0]   chnnl1,

    output logic              cnv_cmplt0,
    output logic              cnv_cmplt1,
    output logic [RES_W-1:0]  res,
    output logic              busy0,
    output logic              busy1,
    output logic              a2d_err,

    a2d_arbiter_if.master     a2d
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    arb_state_t        state_q;
    logic              gnt_q;
    logic              last_gnt_q;
    logic [1:0]        pend_q;
    logic [1:0]        pend_d;
    logic [CH_W-1:0]   chnl0_q;
    logic [CH_W-1:0]   chnl1_q;
    logic [TMR_W-1:0]  timer_q;
    logic [RES_W-1:0]  res_q;
    logic [CH_W-1:0]   a2d_chnnl_q;
    logic              a2d_strt_q;
    logic [1:0]        cmplt_q;
    logic              err_q;

    logic              in_flight0;
    logic              in_flight1;
    logic              busy0_w;
    logic              busy1_w;
    logic              cap0;
    logic              cap1;
    logic              pick_vld;
    logic              pick;

    // -----------------------------------------------------------------------
    // Request capture and busy status
    // -----------------------------------------------------------------------
    // A port is in flight from the grant until the DONE cycle has retired it;
    // a request arriving while the port is busy is dropped so the channel
    // already queued is the one converted.
    assign in_flight0 = (state_q != IDLE) && (gnt_q == 1'b0);
    assign in_flight1 = (state_q != IDLE) && (gnt_q == 1'b1);
    assign busy0_w    = pend_q[0] | in_flight0;
    assign busy1_w    = pend_q[1] | in_flight1;
    assign cap0       = strt_cnv0 & ~busy0_w;
    assign cap1       = strt_cnv1 & ~busy1_w;

    // A port cannot capture in its own DONE cycle (it is still busy), so the
    // set and clear terms below never collide on the same bit.
    always_comb begin
        pend_d = pend_q | {cap1, cap0};
        if (state_q == DONE) begin
            pend_d[gnt_q] = 1'b0;
        end
    end

    a2d_rr_pick u_rr_pick (
        .pend_i     (pend_q),
        .last_gnt_i (last_gnt_q),
        .gnt_vld_o  (pick_vld),
        .gnt_o      (pick)
    );

    // -----------------------------------------------------------------------
    // Channel latches
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chnl0_q <= '0;
            chnl1_q <= '0;
        end else begin
            if (cap0) chnl0_q <= chnnl0;
            if (cap1) chnl1_q <= chnnl1;
        end
    end

    // -----------------------------------------------------------------------
    // Arbitration FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            pend_q      <= 2'b00;
            timer_q     <= '0;
            res_q       <= '0;
            a2d_chnnl_q <= '0;
            a2d_strt_q  <= 1'b0;
            cmplt_q     <= 2'b00;
            err_q       <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            a2d_strt_q <= 1'b0;
            cmplt_q    <= 2'b00;

            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q       <= pick;
                        a2d_chnnl_q <= pick ? chnl1_q : chnl0_q;
                        timer_q     <= '0;
                        // Raised here so the pulse lines up with the LAUNCH cycle
                        a2d_strt_q  <= 1'b1;
                        state_q     <= LAUNCH;
                    end
                end

                LAUNCH: begin
                    state_q <= CONVERT;
                end

                CONVERT: begin
                    // A completion in the final timer cycle still wins over
                    // the abort.
                    if (a2d.a2d_cnv_cmplt) begin
                        res_q   <= a2d.a2d_res;
                        state_q <= DONE;
                    end else if (timer_q == TMR_LAST) begin
                        res_q   <= '0;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                DONE: begin
                    cmplt_q    <= gnt_q ? 2'b10 : 2'b01;
                    last_gnt_q <= gnt_q;
                    state_q    <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign a2d.a2d_strt_cnv = a2d_strt_q;
    assign a2d.a2d_chnnl    = a2d_chnnl_q;

    assign cnv_cmplt0 = cmplt_q[0];
    assign cnv_cmplt1 = cmplt_q[1];
    assign res        = res_q;
    assign busy0      = busy0_w;
    assign busy1      = busy1_w;
    assign a2d_err    = err_q;

endmodule

// File: tb/tb_a2d_arbiter.sv
// ---------------------------------------------------------------------------
// tb_a2d_arbiter
// Directed bench for a2d_arbiter. Inputs are driven 1 time unit after the
// rising edge and outputs are sampled at that same point, so a value read
// after tick() is the value registered on the edge just passed.
// ---------------------------------------------------------------------------
module tb_a2d_arbiter;
    import a2d_arb_pkg::*;

    localparam int TIMEOUT_CYC = 1023;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              strt_cnv0, strt_cnv1;
    logic [2:0]        chnnl0, chnnl1;
    logic              cnv_cmplt0, cnv_cmplt1;
    logic [11:0]       res;
    logic              busy0, busy1;
    logic              a2d_err;

    a2d_arbiter_if a2d_bus ();

    a2d_arbiter #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMR_W       (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .strt_cnv0  (strt_cnv0),
        .chnnl0     (chnnl0),
        .strt_cnv1  (strt_cnv1),
        .chnnl1     (chnnl1),
        .cnv_cmplt0 (cnv_cmplt0),
        .cnv_cmplt1 (cnv_cmplt1),
        .res        (res),
        .busy0      (busy0),
        .busy1      (busy1),
        .a2d_err    (a2d_err),
        .a2d        (a2d_bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_strt   = 0;
    int n_cmplt  = 0;
    bit both_seen = 1'b0;

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (a2d_bus.a2d_strt_cnv === 1'b1) n_strt <= n_strt + 1;
        if (cnv_cmplt0 === 1'b1 || cnv_cmplt1 === 1'b1) n_cmplt <= n_cmplt + 1;
        if (cnv_cmplt0 === 1'b1 && cnv_cmplt1 === 1'b1) both_seen <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        strt_cnv0 = 1'b0; strt_cnv1 = 1'b0;
        chnnl0 = 3'd0;    chnnl1 = 3'd0;
        a2d_bus.a2d_cnv_cmplt = 1'b0;
        a2d_bus.a2d_res = 12'h000;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic request(input bit port, input logic [2:0] ch);
        if (port) begin strt_cnv1 = 1'b1; chnnl1 = ch; end
        else      begin strt_cnv0 = 1'b1; chnnl0 = ch; end
        tick();
        strt_cnv0 = 1'b0; strt_cnv1 = 1'b0;
        chnnl0 = 3'd6;    chnnl1 = 3'd6;
    endtask

    task automatic request_both(input logic [2:0] ch0, input logic [2:0] ch1);
        strt_cnv0 = 1'b1; chnnl0 = ch0;
        strt_cnv1 = 1'b1; chnnl1 = ch1;
        tick();
        strt_cnv0 = 1'b0; strt_cnv1 = 1'b0;
        chnnl0 = 3'd6;    chnnl1 = 3'd6;
    endtask

    // Waits for a start pulse, checking the current cycle before advancing
    task automatic wait_launch(input int max, output bit ok, output logic [2:0] ch);
        ok = 1'b0;
        ch = 3'd0;
        for (int i = 0; i < max; i++) begin
            if (a2d_bus.a2d_strt_cnv === 1'b1) begin
                ok = 1'b1;
                ch = a2d_bus.a2d_chnnl;
                break;
            end
            tick();
        end
    endtask

    task automatic answer(input int delay, input logic [11:0] val);
        repeat (delay) tick();
        a2d_bus.a2d_cnv_cmplt = 1'b1;
        a2d_bus.a2d_res = val;
        tick();
        a2d_bus.a2d_cnv_cmplt = 1'b0;
        a2d_bus.a2d_res = 12'hEEE;
    endtask

    task automatic wait_done(input int max, output bit ok, output logic [1:0] who,
                             output logic [11:0] r);
        ok = 1'b0;
        who = 2'b00;
        r = 12'h000;
        for (int i = 0; i < max; i++) begin
            if (cnv_cmplt0 === 1'b1 || cnv_cmplt1 === 1'b1) begin
                ok = 1'b1;
                who = {cnv_cmplt1, cnv_cmplt0};
                r = res;
                break;
            end
            tick();
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        strt_cnv0 = 1'b0; strt_cnv1 = 1'b0;
        chnnl0 = 3'd0;    chnnl1 = 3'd0;
        a2d_bus.a2d_cnv_cmplt = 1'b0;
        a2d_bus.a2d_res = 12'h000;
        tick();
        checks++;
        if ({cnv_cmplt0, cnv_cmplt1, busy0, busy1, a2d_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {cnv_cmplt0, cnv_cmplt1, busy0, busy1, a2d_err});
        end
        checks++;
        if (res !== 12'h000) begin
            failures++; $display("FAIL reset_res got=%h exp=000", res);
        end
        checks++;
        if (a2d_bus.a2d_strt_cnv !== 1'b0 || a2d_bus.a2d_chnnl !== 3'd0) begin
            failures++;
            $display("FAIL reset_a2d got strt=%b ch=%0d exp strt=0 ch=0", a2d_bus.a2d_strt_cnv, a2d_bus.a2d_chnnl);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int s0;
        do_reset();
        s0 = n_strt;
        strt_cnv0 = 1'b1; chnnl0 = 3'b100;
        tick();                       // t+1
        strt_cnv0 = 1'b0; chnnl0 = 3'd0;
        checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b0 || a2d_bus.a2d_strt_cnv !== 1'b0) begin
            failures++;
            $display("FAIL single_pend got busy0=%b busy1=%b strt=%b exp 1 0 0", busy0, busy1, a2d_bus.a2d_strt_cnv);
        end
        tick();                       // t+2
        checks++;
        if (a2d_bus.a2d_strt_cnv !== 1'b1 || a2d_bus.a2d_chnnl !== 3'b100) begin
            failures++;
            $display("FAIL single_launch got strt=%b ch=%0d exp strt=1 ch=4", a2d_bus.a2d_strt_cnv, a2d_bus.a2d_chnnl);
        end
        tick();                       // t+3
        checks++;
        if (a2d_bus.a2d_strt_cnv !== 1'b0 || a2d_bus.a2d_chnnl !== 3'b100) begin
            failures++;
            $display("FAIL single_strt_width got strt=%b ch=%0d exp strt=0 ch=4", a2d_bus.a2d_strt_cnv, a2d_bus.a2d_chnnl);
        end
        repeat (38) tick();
        a2d_bus.a2d_cnv_cmplt = 1'b1; a2d_bus.a2d_res = 12'h5A5;
        tick();                       // c+1 : DONE
        a2d_bus.a2d_cnv_cmplt = 1'b0; a2d_bus.a2d_res = 12'h000;
        checks++;
        if (cnv_cmplt0 !== 1'b0 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL single_c1 got cmplt0=%b busy0=%b exp 0 1", cnv_cmplt0, busy0);
        end
        tick();                       // c+2 : pulse
        checks++;
        if (cnv_cmplt0 !== 1'b1 || cnv_cmplt1 !== 1'b0 || res !== 12'h5A5 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL single_done got cmplt0=%b cmplt1=%b res=%h busy0=%b exp 1 0 5a5 0",
                     cnv_cmplt0, cnv_cmplt1, res, busy0);
        end
        tick();
        checks++;
        if (cnv_cmplt0 !== 1'b0 || res !== 12'h5A5) begin
            failures++;
            $display("FAIL single_hold got cmplt0=%b res=%h exp 0 5a5", cnv_cmplt0, res);
        end
        checks++;
        if (n_strt - s0 !== 1) begin
            failures++; $display("FAIL single_nstrt got=%0d exp=1", n_strt - s0);
        end
    endtask

    task automatic test_simultaneous();
        int s0;
        bit ok;
        logic [2:0] ch;
        logic [1:0] who;
        logic [11:0] r;
        do_reset();
        s0 = n_strt;
        request_both(CH_OUT_L, CH_BATT);
        wait_launch(10, ok, ch);
        checks++;
        if (!ok || ch !== CH_OUT_L) begin
            failures++; $display("FAIL simul_launch0 got ok=%b ch=%0d exp ok=1 ch=7", ok, ch);
        end
        answer(10, 12'h111);
        wait_done(6, ok, who, r);
        checks++;
        if (!ok || who !== 2'b01 || r !== 12'h111) begin
            failures++; $display("FAIL simul_done0 got ok=%b who=%b res=%h exp 1 01 111", ok, who, r);
        end
        wait_launch(10, ok, ch);
        checks++;
        if (!ok || ch !== CH_BATT) begin
            failures++; $display("FAIL simul_launch1 got ok=%b ch=%0d exp ok=1 ch=5", ok, ch);
        end
        answer(10, 12'h222);
        wait_done(6, ok, who, r);
        checks++;
        if (!ok || who !== 2'b10 || r !== 12'h222) begin
            failures++; $display("FAIL simul_done1 got ok=%b who=%b res=%h exp 1 10 222", ok, who, r);
        end
        repeat (6) tick();
        checks++;
        if (n_strt - s0 !== 2) begin
            failures++; $display("FAIL simul_nstrt got=%0d exp=2", n_strt - s0);
        end
    endtask

    task automatic test_fairness();
        bit ok;
        logic [2:0] ch;
        logic [1:0] who;
        logic [11:0] r;
        logic [1:0] exp_who;
        logic [2:0] exp_ch;
        do_reset();
        request_both(CH_OUT_R, CH_BATT);
        for (int k = 0; k < 6; k++) begin
            exp_who = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_ch  = (k % 2 == 0) ? CH_OUT_R : CH_BATT;
            wait_launch(10, ok, ch);
            checks++;
            if (!ok || ch !== exp_ch) begin
                failures++; $display("FAIL fair_launch%0d got ok=%b ch=%0d exp ch=%0d", k, ok, ch, exp_ch);
            end
            answer(3 + k, 12'h300 + 12'(k));
            wait_done(6, ok, who, r);
            checks++;
            if (!ok || who !== exp_who || r !== 12'h300 + 12'(k)) begin
                failures++;
                $display("FAIL fair_done%0d got ok=%b who=%b res=%h exp who=%b", k, ok, who, r, exp_who);
            end
            if (k < 5) request(who[1], who[1] ? CH_BATT : CH_OUT_R);
        end
    endtask

    task automatic test_duplicate();
        int s0, c0;
        bit ok;
        logic [2:0] ch;
        logic [1:0] who;
        logic [11:0] r;
        do_reset();
        s0 = n_strt;
        c0 = n_cmplt;
        request(1'b0, CH_IN_R);
        request(1'b0, CH_OUT_L);      // arrives while busy0: dropped
        wait_launch(10, ok, ch);
        checks++;
        if (!ok || ch !== CH_IN_R) begin
            failures++; $display("FAIL dup_launch got ok=%b ch=%0d exp ch=1", ok, ch);
        end
        answer(5, 12'h0A1);
        wait_done(6, ok, who, r);
        checks++;
        if (!ok || who !== 2'b01 || r !== 12'h0A1) begin
            failures++; $display("FAIL dup_done got ok=%b who=%b res=%h exp 1 01 0a1", ok, who, r);
        end
        repeat (12) tick();
        checks++;
        if (n_strt - s0 !== 1 || n_cmplt - c0 !== 1 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL dup_count got strt=%0d cmplt=%0d busy0=%b exp 1 1 0", n_strt - s0, n_cmplt - c0, busy0);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [2:0] ch;
        logic [1:0] who;
        logic [11:0] r;
        int cnt;
        do_reset();
        request(1'b0, CH_IN_L);
        wait_launch(10, ok, ch);
        answer(4, 12'hFFF);
        wait_done(6, ok, who, r);
        checks++;
        if (!ok || r !== 12'hFFF) begin
            failures++; $display("FAIL tmo_pre got ok=%b res=%h exp 1 fff", ok, r);
        end
        request(1'b1, CH_BATT);
        wait_launch(10, ok, ch);
        checks++;
        if (!ok || ch !== CH_BATT || a2d_err !== 1'b0) begin
            failures++; $display("FAIL tmo_launch got ok=%b ch=%0d err=%b exp 1 5 0", ok, ch, a2d_err);
        end
        cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < TIMEOUT_CYC + 80; i++) begin
            tick();
            cnt++;
            if (cnv_cmplt0 === 1'b1 || cnv_cmplt1 === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || cnt !== TIMEOUT_CYC + 2) begin
            failures++; $display("FAIL tmo_latency got ok=%b cycles=%0d exp %0d", ok, cnt, TIMEOUT_CYC + 2);
        end
        checks++;
        if (cnv_cmplt1 !== 1'b1 || cnv_cmplt0 !== 1'b0 || res !== 12'h000 || a2d_err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_abort got cmplt1=%b cmplt0=%b res=%h err=%b exp 1 0 000 1",
                     cnv_cmplt1, cnv_cmplt0, res, a2d_err);
        end
        request(1'b0, CH_MID_L);
        wait_launch(10, ok, ch);
        checks++;
        if (!ok || ch !== CH_MID_L) begin
            failures++; $display("FAIL tmo_next_launch got ok=%b ch=%0d exp ch=2", ok, ch);
        end
        answer(3, 12'h123);
        wait_done(6, ok, who, r);
        checks++;
        if (!ok || who !== 2'b01 || r !== 12'h123 || a2d_err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_next_done got ok=%b who=%b res=%h err=%b exp 1 01 123 1", ok, who, r, a2d_err);
        end
    endtask

    // Follows test_timeout directly so a2d_err and res are non-zero going in
    task automatic test_reset_mid_convert();
        int s0, c0;
        bit ok;
        logic [2:0] ch;
        request(1'b0, CH_IN_R);
        wait_launch(10, ok, ch);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL rstmid_launch got ok=%b exp 1", ok);
        end
        repeat (5) tick();
        s0 = n_strt;
        c0 = n_cmplt;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cnv_cmplt0, cnv_cmplt1, busy0, busy1, a2d_err, a2d_bus.a2d_strt_cnv} !== 6'b0 ||
            res !== 12'h000 || a2d_bus.a2d_chnnl !== 3'd0) begin
            failures++;
            $display("FAIL rstmid_outputs got flags=%b res=%h ch=%0d exp 000000 000 0",
                     {cnv_cmplt0, cnv_cmplt1, busy0, busy1, a2d_err, a2d_bus.a2d_strt_cnv},
                     res, a2d_bus.a2d_chnnl);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        a2d_bus.a2d_cnv_cmplt = 1'b1; a2d_bus.a2d_res = 12'h777;
        tick();
        a2d_bus.a2d_cnv_cmplt = 1'b0; a2d_bus.a2d_res = 12'h000;
        repeat (6) tick();
        checks++;
        if (n_cmplt - c0 !== 0 || n_strt - s0 !== 0 || res !== 12'h000 ||
            busy0 !== 1'b0 || a2d_err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_late got cmplt=%0d strt=%0d res=%h busy0=%b err=%b exp 0 0 000 0 0",
                     n_cmplt - c0, n_strt - s0, res, busy0, a2d_err);
        end
    endtask

    task automatic test_exclusive_pulses();
        checks++;
        if (both_seen !== 1'b0) begin
            failures++; $display("FAIL excl_cmplt got both_high=%b exp 0", both_seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_duplicate();
        test_timeout();
        test_reset_mid_convert();
        test_exclusive_pulses();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
